// File: rtl/noc_inject_arbiter.sv
// Round-robin, wormhole-locked arbiter that lets several flit sources share one NoC
// injection port. It also counts delivered packets and flags sources that break protocol.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = `Noc_Data_Width,
  parameter int CNT_W   = 16
) (
  input  logic                        noc_clk,
  input  logic                        noc_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_flit,
  input  logic [NUM_REQ-1:0]          req_is_header,
  input  logic [NUM_REQ-1:0]          req_is_tail,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_flit,
  output logic                        out_is_header,
  output logic                        out_is_tail,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy,
  output logic [NUM_REQ-1:0]          proto_err,
  input  logic                        err_clr,
  output logic [CNT_W-1:0]            pkt_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]         state_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [PTR_W-1:0]   rr_ptr_r;
  logic [CNT_W-1:0]   pkt_cnt_r;
  logic [NUM_REQ-1:0] proto_err_r;

  logic [NUM_REQ-1:0] cand_s;
  logic               any_cand_s;
  logic [PTR_W-1:0]   win_idx_s;
  logic [NUM_REQ-1:0] win_oh_s;
  logic [PTR_W-1:0]   owner_s;
  logic [PTR_W-1:0]   next_ptr_s;
  logic               release_s;
  logic [NUM_REQ-1:0] proto_set_s;
  logic [NUM_REQ-1:0] proto_nxt_s;

  assign cand_s     = req_valid & req_is_header;
  assign any_cand_s = |cand_s;

  // Round-robin pick: scan from the highest-offset slot down so the slot nearest rr_ptr wins.
  always_comb begin
    int idx_v;
    idx_v     = 0;
    win_idx_s = {PTR_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_v     = int'(rr_ptr_r) + k;
      idx_v     = (idx_v >= NUM_REQ) ? (idx_v - NUM_REQ) : idx_v;
      win_idx_s = cand_s[idx_v] ? PTR_W'(idx_v) : win_idx_s;
    end
    win_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
  end

  // AND-OR mux of the owner's flit; grant_r is zero in IDLE so every output collapses to 0.
  always_comb begin
    owner_s       = {PTR_W{1'b0}};
    out_flit      = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_s  = owner_s | (grant_r[i] ? PTR_W'(i) : {PTR_W{1'b0}});
      out_flit = out_flit | (grant_r[i] ? req_flit[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
    end
    out_valid     = |(grant_r & req_valid);
    out_is_header = |(grant_r & req_is_header);
    out_is_tail   = |(grant_r & req_is_tail);
    req_ready     = grant_r & {NUM_REQ{out_ready}};
  end

  assign release_s   = (state_r == ST_LOCKED) && out_valid && out_ready && out_is_tail;
  assign next_ptr_s  = (owner_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : (owner_s + PTR_W'(1));
  // A body/tail flit from anyone but the owner is a violation; set beats clear.
  assign proto_set_s = req_valid & ~req_is_header & ~grant_r;
  assign proto_nxt_s = err_clr ? proto_set_s : (proto_err_r | proto_set_s);

  // Arbitration state, ownership and round-robin pointer.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_r  <= ST_IDLE;
      grant_r  <= {NUM_REQ{1'b0}};
      rr_ptr_r <= {PTR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_cand_s) begin
            state_r <= ST_LOCKED;
            grant_r <= win_oh_s;
          end else begin
            state_r <= ST_IDLE;
            grant_r <= {NUM_REQ{1'b0}};
          end
        end
        ST_LOCKED: begin
          if (release_s) begin
            state_r  <= ST_IDLE;
            grant_r  <= {NUM_REQ{1'b0}};
            rr_ptr_r <= next_ptr_s;
          end else begin
            state_r <= ST_LOCKED;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

  // Packet counter and sticky protocol-error flags.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      pkt_cnt_r   <= {CNT_W{1'b0}};
      proto_err_r <= {NUM_REQ{1'b0}};
    end else begin
      proto_err_r <= proto_nxt_s;
      if (release_s) begin
        pkt_cnt_r <= pkt_cnt_r + CNT_W'(1);
      end else begin
        pkt_cnt_r <= pkt_cnt_r;
      end
    end
  end

  assign grant     = grant_r;
  assign busy      = (state_r == ST_LOCKED);
  assign proto_err = proto_err_r;
  assign pkt_cnt   = pkt_cnt_r;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter: reset, single packet, contention, backpressure,
// single-flit packets, protocol errors and reset in the middle of a packet.
`timescale 1ns/1ps

module tb_noc_inject_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;

  logic                      noc_clk;
  logic                      noc_rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        req_is_header;
  logic [NUM_REQ-1:0]        req_is_tail;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_flit;
  logic                      out_is_header;
  logic                      out_is_tail;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic [NUM_REQ-1:0]        proto_err;
  logic                      err_clr;
  logic [CNT_W-1:0]          pkt_cnt;

  int checks   = 0;
  int failures = 0;

  noc_inject_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_flit(req_flit),
    .req_is_header(req_is_header), .req_is_tail(req_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .out_is_header(out_is_header), .out_is_tail(out_is_tail),
    .grant(grant), .busy(busy), .proto_err(proto_err), .err_clr(err_clr),
    .pkt_cnt(pkt_cnt)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  task automatic drive(input int i, input logic v, input logic h, input logic t,
                       input logic [DATA_W-1:0] f);
    req_valid[i]               = v;
    req_is_header[i]           = h;
    req_is_tail[i]             = t;
    req_flit[i*DATA_W +: DATA_W] = f;
  endtask

  task automatic clear_all();
    req_valid     = '0;
    req_is_header = '0;
    req_is_tail   = '0;
    req_flit      = '0;
  endtask

  task automatic next_cycle();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic test_reset();
    noc_rst_n = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    clear_all();
    #12;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (pkt_cnt !== 16'd0) begin failures++; $display("FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt); end
    checks++; if (proto_err !== 4'b0000) begin failures++; $display("FAIL reset_proto_err: got %b expected 0000", proto_err); end
    checks++; if ({out_flit, out_is_header, out_is_tail} !== 34'd0) begin failures++; $display("FAIL reset_out_flit: got %h/%b/%b expected 0", out_flit, out_is_header, out_is_tail); end
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_packet();
    out_ready = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b0, 32'hA000_0001);
    @(negedge noc_clk);
    checks++; if ({out_valid, req_ready} !== 5'b0_0000) begin failures++; $display("FAIL single_arb_cycle: got valid=%b ready=%b expected 0/0000", out_valid, req_ready); end
    next_cycle();
    @(negedge noc_clk);
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b expected 0001", grant); end
    checks++; if ({busy, out_valid, out_is_header} !== 3'b111) begin failures++; $display("FAIL single_hdr_flags: got %b expected 111", {busy, out_valid, out_is_header}); end
    checks++; if (out_flit !== 32'hA000_0001) begin failures++; $display("FAIL single_hdr_flit: got %h expected a0000001", out_flit); end
    next_cycle();
    drive(0, 1'b1, 1'b0, 1'b0, 32'hA000_0002);
    @(negedge noc_clk);
    checks++; if (out_flit !== 32'hA000_0002) begin failures++; $display("FAIL single_data_flit: got %h expected a0000002", out_flit); end
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_req_ready: got %b expected 0001", req_ready); end
    next_cycle();
    drive(0, 1'b1, 1'b0, 1'b1, 32'hA000_0003);
    @(negedge noc_clk);
    checks++; if ({out_flit, out_is_tail} !== {32'hA000_0003, 1'b1}) begin failures++; $display("FAIL single_tail_flit: got %h/%b expected a0000003/1", out_flit, out_is_tail); end
    next_cycle();
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge noc_clk);
    checks++; if ({grant, busy} !== 5'b0000_0) begin failures++; $display("FAIL single_release: got grant=%b busy=%b expected 0000/0", grant, busy); end
    checks++; if (pkt_cnt !== 16'd1) begin failures++; $display("FAIL single_pkt_cnt: got %0d expected 1", pkt_cnt); end
  endtask

  task automatic test_contention();
    drive(1, 1'b1, 1'b1, 1'b0, 32'h11);
    drive(3, 1'b1, 1'b1, 1'b0, 32'h31);
    next_cycle();
    @(negedge noc_clk);
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL cont_first_grant: got %b expected 0010", grant); end
    checks++; if ({out_flit, req_ready} !== {32'h11, 4'b0010}) begin failures++; $display("FAIL cont_first_flit: got %h/%b expected 11/0010", out_flit, req_ready); end
    next_cycle();
    drive(1, 1'b1, 1'b0, 1'b1, 32'h12);
    next_cycle();
    drive(1, 1'b1, 1'b1, 1'b1, 32'h13);
    @(negedge noc_clk);
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL cont_gap: got %b expected 0000", grant); end
    next_cycle();
    @(negedge noc_clk);
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL cont_second_grant: got %b expected 1000", grant); end
    checks++; if (out_flit !== 32'h31) begin failures++; $display("FAIL cont_second_flit: got %h expected 31", out_flit); end
    next_cycle();
    drive(3, 1'b1, 1'b0, 1'b1, 32'h32);
    next_cycle();
    drive(3, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    @(negedge noc_clk);
    checks++; if ({grant, out_flit, out_is_tail} !== {4'b0010, 32'h13, 1'b1}) begin failures++; $display("FAIL cont_third: got %b/%h/%b expected 0010/13/1", grant, out_flit, out_is_tail); end
    next_cycle();
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge noc_clk);
    checks++; if (pkt_cnt !== 16'd4) begin failures++; $display("FAIL cont_pkt_cnt: got %0d expected 4", pkt_cnt); end
    checks++; if (proto_err !== 4'b0000) begin failures++; $display("FAIL cont_no_err: got %b expected 0000", proto_err); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] flits [3];
    logic [DATA_W-1:0] rec [3];
    logic              ready_seq [5];
    int idx;
    int got;
    flits     = '{32'h21, 32'h22, 32'h23};
    rec       = '{32'h0, 32'h0, 32'h0};
    ready_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    idx = 0;
    got = 0;
    out_ready = 1'b1;
    drive(2, 1'b1, 1'b1, 1'b0, flits[0]);
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      out_ready = ready_seq[c];
      drive(2, 1'b1, idx == 0, idx == 2, flits[idx]);
      @(negedge noc_clk);
      checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL bp_grant_hold c%0d: got %b expected 0100", c, grant); end
      checks++; if (req_ready !== {1'b0, ready_seq[c], 2'b00}) begin failures++; $display("FAIL bp_req_ready c%0d: got %b expected %b", c, req_ready, {1'b0, ready_seq[c], 2'b00}); end
      if (out_valid && out_ready) begin
        if (got < 3) rec[got] = out_flit;
        got++;
        if (idx < 2) idx++;
      end
      next_cycle();
    end
    drive(2, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge noc_clk);
    checks++; if (got !== 3) begin failures++; $display("FAIL bp_count: got %0d expected 3", got); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rec[i] !== flits[i]) begin failures++; $display("FAIL bp_flit%0d: got %h expected %h", i, rec[i], flits[i]); end
    end
    checks++; if ({grant, pkt_cnt} !== {4'b0000, 16'd5}) begin failures++; $display("FAIL bp_release: got %b/%0d expected 0000/5", grant, pkt_cnt); end
  endtask

  task automatic test_single_flit();
    out_ready = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b1, 32'h01);
    next_cycle();
    @(negedge noc_clk);
    checks++; if ({grant, req_ready} !== {4'b0001, 4'b0001}) begin failures++; $display("FAIL sflit_grant: got %b/%b expected 0001/0001", grant, req_ready); end
    checks++; if ({out_is_header, out_is_tail, out_flit} !== {2'b11, 32'h01}) begin failures++; $display("FAIL sflit_flags: got %b%b/%h expected 11/01", out_is_header, out_is_tail, out_flit); end
    next_cycle();
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge noc_clk);
    checks++; if ({grant, pkt_cnt} !== {4'b0000, 16'd6}) begin failures++; $display("FAIL sflit_release: got %b/%0d expected 0000/6", grant, pkt_cnt); end
  endtask

  task automatic test_proto_err();
    out_ready = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h41);
    next_cycle();
    out_ready = 1'b1;
    drive(1, 1'b1, 1'b0, 1'b0, 32'h55);
    @(negedge noc_clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL perr_ready: got %b expected 0001", req_ready); end
    next_cycle();
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h42);
    out_ready = 1'b0;
    @(negedge noc_clk);
    checks++; if (proto_err !== 4'b0010) begin failures++; $display("FAIL perr_set: got %b expected 0010", proto_err); end
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    @(negedge noc_clk);
    checks++; if (proto_err !== 4'b0000) begin failures++; $display("FAIL perr_clear: got %b expected 0000", proto_err); end
    drive(1, 1'b1, 1'b0, 1'b0, 32'h56);
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge noc_clk);
    checks++; if (proto_err !== 4'b0010) begin failures++; $display("FAIL perr_set_wins: got %b expected 0010", proto_err); end
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL perr_stall_grant: got %b expected 0001", grant); end
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    out_ready = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b1, 32'h43);
    @(negedge noc_clk);
    checks++; if (proto_err !== 4'b0000) begin failures++; $display("FAIL perr_clear2: got %b expected 0000", proto_err); end
    next_cycle();
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge noc_clk);
    checks++; if ({grant, pkt_cnt} !== {4'b0000, 16'd7}) begin failures++; $display("FAIL perr_release: got %b/%0d expected 0000/7", grant, pkt_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    out_ready = 1'b1;
    drive(2, 1'b1, 1'b1, 1'b0, 32'h61);
    next_cycle();
    next_cycle();
    drive(2, 1'b1, 1'b0, 1'b0, 32'h62);
    @(negedge noc_clk);
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL rmid_grant: got %b expected 0100", grant); end
    next_cycle();
    drive(2, 1'b1, 1'b0, 1'b1, 32'h63);
    noc_rst_n = 1'b0;
    #1;
    checks++; if ({grant, out_valid, busy, req_ready} !== 10'd0) begin failures++; $display("FAIL rmid_clear: got grant=%b valid=%b busy=%b ready=%b expected all 0", grant, out_valid, busy, req_ready); end
    checks++; if (pkt_cnt !== 16'd0) begin failures++; $display("FAIL rmid_pkt_cnt: got %0d expected 0", pkt_cnt); end
    clear_all();
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    next_cycle();
    drive(0, 1'b1, 1'b1, 1'b1, 32'h71);
    drive(2, 1'b1, 1'b1, 1'b1, 32'h72);
    next_cycle();
    @(negedge noc_clk);
    checks++; if ({grant, out_flit} !== {4'b0001, 32'h71}) begin failures++; $display("FAIL rmid_rr_restart: got %b/%h expected 0001/71", grant, out_flit); end
    next_cycle();
    clear_all();
    next_cycle();
    @(negedge noc_clk);
    checks++; if ({grant, pkt_cnt, proto_err} !== {4'b0000, 16'd1, 4'b0000}) begin failures++; $display("FAIL rmid_final: got %b/%0d/%b expected 0000/1/0000", grant, pkt_cnt, proto_err); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_contention();
    test_backpressure();
    test_single_flit();
    test_proto_err();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
